fetch_queue_stage: RTL and testbench

Parametrised successor of the single-register fetch stage. Owns the PC and issues one instruction fetch per cycle to the instruction cache over a request/response handshake. Buffers returned instructions with their PCs in a FIFO_DEPTH-entry queue that decode drains with valid/ready. Handles cache-miss stall/replay and branch redirect with flush. Sits between the PC-select logic (branch_hit/PCbranch from execute) and the decode stage.

---
 rtl/fetch_queue_stage_pkg.sv | 12 +
 rtl/fetch_queue_stage_fifo.sv | 51 +++++
 rtl/fetch_queue_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_queue_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_stage_pkg.sv
// Shared defaults and fetch-state encoding for the fetch queue stage.
package fetch_queue_stage_pkg;
    localparam int          VIRT_ADDR_WIDTH = 32;
    localparam int          INST_WIDTH      = 32;
    localparam logic [31:0] RESET_PC        = 32'h0000_1000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        MISS  = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// Power-of-two circular buffer with push/pop/flush; flush wins over push and pop.
module fetch_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC owner, single-outstanding I-cache request, miss replay, redirect flush.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_queue_stage #(
    parameter int                         VIRT_ADDR_WIDTH = fetch_queue_stage_pkg::VIRT_ADDR_WIDTH,
    parameter int                         INST_WIDTH      = fetch_queue_stage_pkg::INST_WIDTH,
    parameter int                         FIFO_DEPTH      = 4,
    parameter logic [VIRT_ADDR_WIDTH-1:0] RESET_PC        = VIRT_ADDR_WIDTH'(fetch_queue_stage_pkg::RESET_PC),
    parameter int                         PC_STEP         = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       branch_hit,
    input  logic [VIRT_ADDR_WIDTH-1:0] PCbranch,
    output logic                       ic_req,
    output logic [VIRT_ADDR_WIDTH-1:0] ic_addr,
    input  logic                       ic_rsp_valid,
    input  logic                       ic_rsp_hit,
    input  logic [INST_WIDTH-1:0]      ic_rsp_instr,
    input  logic                       ic_fill_done,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [INST_WIDTH-1:0]      instruction,
    output logic [VIRT_ADDR_WIDTH-1:0] PCnext,
    output logic                       fetch_stall
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_miss,
    output logic [31:0]                perf_stall
`endif
);
    import fetch_queue_stage_pkg::*;

    localparam int                         ENTRY_W = INST_WIDTH + VIRT_ADDR_WIDTH;
    localparam int                         CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int                         OCC_W   = CNT_W + 1;
    localparam logic [OCC_W-1:0]           DEPTH_L = OCC_W'(FIFO_DEPTH);
    localparam logic [VIRT_ADDR_WIDTH-1:0] STEP_L  = VIRT_ADDR_WIDTH'(PC_STEP);

    fetch_state_e                 state, state_n;
    logic [VIRT_ADDR_WIDTH-1:0]   pc, pc_n;
    logic [VIRT_ADDR_WIDTH-1:0]   req_addr;
    logic                         epoch, epoch_n;
    logic                         req_epoch, req_epoch_n;
    logic                         issue, push, pop, flush;
    logic                         can_issue;
    logic [OCC_W-1:0]             occ;
    logic [CNT_W-1:0]             count;
    logic                         full, empty;
    logic [ENTRY_W-1:0]           head;
    logic [ENTRY_W-1:0]           push_data;

    assign push_data = {ic_rsp_instr, req_addr + STEP_L};
    assign pop       = dec_valid && dec_ready && !branch_hit;

    fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (push_data),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // The in-flight request reserves a queue slot, so occupancy counts it in WAIT.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        epoch_n     = epoch;
        req_epoch_n = req_epoch;
        issue       = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        occ         = OCC_W'(count) + ((state == WAIT) ? OCC_W'(1) : OCC_W'(0));
        can_issue   = reset && !full && (occ < DEPTH_L);
        if (branch_hit) begin
            flush   = 1'b1;
            pc_n    = PCbranch;
            epoch_n = ~epoch;
            state_n = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (can_issue) begin
                        issue   = 1'b1;
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (ic_rsp_valid && (req_epoch == epoch)) begin
                        if (ic_rsp_hit) begin
                            push    = 1'b1;
                            state_n = FETCH;
                            if (can_issue) begin
                                issue   = 1'b1;
                                state_n = WAIT;
                            end
                        end else begin
                            pc_n    = req_addr;
                            state_n = MISS;
                        end
                    end else if (ic_rsp_valid) begin
                        state_n = FETCH;
                    end
                end
                MISS: begin
                    if (ic_fill_done) state_n = FETCH;
                end
                default: state_n = FETCH;
            endcase
            if (issue) begin
                pc_n        = pc + STEP_L;
                req_epoch_n = epoch;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            epoch     <= 1'b0;
            req_epoch <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            epoch     <= epoch_n;
            req_epoch <= req_epoch_n;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) req_addr <= pc;
    end

    assign ic_req      = issue;
    assign ic_addr     = pc;
    assign dec_valid   = !empty;
    assign instruction = dec_valid ? head[ENTRY_W-1 -: INST_WIDTH] : '0;
    assign PCnext      = dec_valid ? head[VIRT_ADDR_WIDTH-1:0] : '0;
    assign fetch_stall = (state == MISS);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_miss    <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
            if (!branch_hit && (state == WAIT) && ic_rsp_valid && (req_epoch == epoch)
                && !ic_rsp_hit && (perf_miss != '1))
                perf_miss <= perf_miss + 32'd1;
            if ((state == MISS) && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench: behavioural cache + program-order model against fetch_queue_stage.
module tb_fetch_queue_stage;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        branch_hit = 1'b0;
    logic [31:0] PCbranch = '0;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_rsp_valid = 1'b0;
    logic        ic_rsp_hit = 1'b0;
    logic [31:0] ic_rsp_instr = '0;
    logic        ic_fill_done = 1'b0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] PCnext;
    logic        fetch_stall;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_miss, perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_queue_stage dut (
        .clk          (clk),
        .reset        (reset),
        .branch_hit   (branch_hit),
        .PCbranch     (PCbranch),
        .ic_req       (ic_req),
        .ic_addr      (ic_addr),
        .ic_rsp_valid (ic_rsp_valid),
        .ic_rsp_hit   (ic_rsp_hit),
        .ic_rsp_instr (ic_rsp_instr),
        .ic_fill_done (ic_fill_done),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .instruction  (instruction),
        .PCnext       (PCnext),
        .fetch_stall  (fetch_stall)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_miss    (perf_miss),
        .perf_stall   (perf_stall)
`endif
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] mq[$];
    logic [31:0] next_fetch, exp_dec;
    bit          miss_pend;
    logic [31:0] rsp_addr;
    bit          rsp_stale;
    int          n_req, n_pop;
    bit          force_armed;
    logic [31:0] force_miss_addr;
    int          miss_pct;

    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        branch_hit = 1'b0; ic_fill_done = 1'b0; ic_rsp_valid = 1'b0;
        ic_rsp_hit = 1'b0; ic_rsp_instr = '0; dec_ready = 1'b0; PCbranch = '0;
        mq.delete();
        next_fetch = 32'h1000; exp_dec = 32'h1000; miss_pend = 0;
        rsp_addr = '0; rsp_stale = 0; n_req = 0; n_pop = 0;
        force_armed = 0; force_miss_addr = '0; miss_pct = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
    endtask

    // One clock: compare outputs at negedge, advance the model, then drive the cache response.
    task automatic cycle();
        bit          cur_req, nxt_valid, nxt_hit, nxt_stale;
        logic [31:0] nxt_addr;
        @(negedge clk);
        n_total++;
        if (dec_valid !== (mq.size() != 0))
            $display("FAIL dec_valid: got %b expected %b", dec_valid, mq.size() != 0);
        else n_pass++;
        if (dec_valid === 1'b1 && mq.size() != 0) begin
            n_total++;
            if (instruction !== f(exp_dec))
                $display("FAIL instruction: got %h expected %h", instruction, f(exp_dec));
            else n_pass++;
            n_total++;
            if (PCnext !== exp_dec + 32'd4)
                $display("FAIL PCnext: got %h expected %h", PCnext, exp_dec + 32'd4);
            else n_pass++;
        end
        n_total++;
        if (fetch_stall !== miss_pend)
            $display("FAIL fetch_stall: got %b expected %b", fetch_stall, miss_pend);
        else n_pass++;
        if (ic_req === 1'b1) begin
            n_total++;
            if (ic_addr !== next_fetch)
                $display("FAIL ic_addr: got %h expected %h", ic_addr, next_fetch);
            else n_pass++;
            n_total++;
            if (miss_pend) $display("FAIL req_during_miss: got ic_req=1 expected 0");
            else n_pass++;
        end
        cur_req = (ic_req === 1'b1);
        if (branch_hit) begin
            mq.delete();
            next_fetch = PCbranch; exp_dec = PCbranch; miss_pend = 0;
        end else begin
            if (dec_valid === 1'b1 && dec_ready && mq.size() != 0) begin
                void'(mq.pop_front());
                exp_dec += 32'd4; n_pop++;
            end
            if (cur_req) next_fetch += 32'd4;
            if (ic_fill_done) miss_pend = 0;
            if (ic_rsp_valid && !rsp_stale) begin
                if (ic_rsp_hit) mq.push_back(rsp_addr);
                else begin next_fetch = rsp_addr; miss_pend = 1; end
            end
            n_total++;
            if (mq.size() > DEPTH) $display("FAIL overflow: got %0d entries expected <= %0d", mq.size(), DEPTH);
            else n_pass++;
        end
        nxt_valid = cur_req; nxt_addr = ic_addr; nxt_stale = branch_hit; nxt_hit = 1;
        if (cur_req) begin
            n_req++;
            if (force_armed && ic_addr == force_miss_addr) begin nxt_hit = 0; force_armed = 0; end
            else if ($urandom_range(0, 99) < miss_pct) nxt_hit = 0;
        end
        @(posedge clk);
        #1;
        branch_hit = 1'b0; ic_fill_done = 1'b0;
        ic_rsp_valid = nxt_valid; ic_rsp_hit = nxt_hit;
        ic_rsp_instr = nxt_hit ? f(nxt_addr) : $urandom;
        rsp_addr = nxt_addr; rsp_stale = nxt_stale;
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_total++; if (ic_req !== 1'b0) $display("FAIL rst_ic_req: got %b expected 0", ic_req); else n_pass++;
        n_total++; if (dec_valid !== 1'b0) $display("FAIL rst_dec_valid: got %b expected 0", dec_valid); else n_pass++;
        n_total++; if (instruction !== 32'h0) $display("FAIL rst_instruction: got %h expected 0", instruction); else n_pass++;
        n_total++; if (PCnext !== 32'h0) $display("FAIL rst_PCnext: got %h expected 0", PCnext); else n_pass++;
        n_total++; if (fetch_stall !== 1'b0) $display("FAIL rst_fetch_stall: got %b expected 0", fetch_stall); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        n_total++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h1000) $display("FAIL first_req: got %b/%h expected 1/00001000", ic_req, ic_addr);
        else n_pass++;
        dec_ready = 1'b1;
        repeat (12) cycle();
        n_total++; if (n_pop != 10) $display("FAIL stream_pops: got %0d expected 10", n_pop); else n_pass++;
        n_total++; if (n_req != 12) $display("FAIL stream_reqs: got %0d expected 12", n_req); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        repeat (10) cycle();
        n_total++; if (n_req != DEPTH) $display("FAIL full_reqs: got %0d expected %0d", n_req, DEPTH); else n_pass++;
        n_total++; if (ic_req !== 1'b0) $display("FAIL full_no_req: got %b expected 0", ic_req); else n_pass++;
        dec_ready = 1'b1;
        cycle();
        n_total++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h1010) $display("FAIL full_resume: got %b/%h expected 1/00001010", ic_req, ic_addr);
        else n_pass++;
        repeat (8) cycle();
    endtask

    task automatic test_miss();
        int t;
        do_reset();
        dec_ready = 1'b1; force_miss_addr = 32'h1008; force_armed = 1;
        t = 0;
        while (fetch_stall !== 1'b1 && t < 10) begin cycle(); t++; end
        n_total++; if (fetch_stall !== 1'b1) $display("FAIL miss_timeout: got stall=%b expected 1", fetch_stall); else n_pass++;
        n_total++; if (ic_req !== 1'b0) $display("FAIL miss_no_req: got %b expected 0", ic_req); else n_pass++;
        repeat (3) cycle();
        ic_fill_done = 1'b1;
        cycle();
        n_total++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h1008) $display("FAIL miss_replay: got %b/%h expected 1/00001008", ic_req, ic_addr);
        else n_pass++;
        repeat (8) cycle();
        n_total++; if (exp_dec != 32'h1000 + 32'd4 * n_pop) $display("FAIL miss_order: got %h expected %h", exp_dec, 32'h1000 + 32'd4 * n_pop); else n_pass++;
    endtask

    task automatic test_branch();
        int lat;
        do_reset();
        repeat (4) cycle();
        n_total++; if (mq.size() != 3 || ic_rsp_valid !== 1'b1) $display("FAIL br_setup: got %0d queued expected 3 with response in flight", mq.size()); else n_pass++;
        branch_hit = 1'b1; PCbranch = 32'h2000;
        cycle();
        n_total++; if (dec_valid !== 1'b0) $display("FAIL br_flush: got %b expected 0", dec_valid); else n_pass++;
        n_total++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h2000) $display("FAIL br_target: got %b/%h expected 1/00002000", ic_req, ic_addr);
        else n_pass++;
        dec_ready = 1'b1;
        lat = 1;
        while (dec_valid !== 1'b1 && lat < 10) begin cycle(); lat++; end
        n_total++; if (lat != 3) $display("FAIL br_latency: got %0d expected 3", lat); else n_pass++;
        repeat (5) cycle();
    endtask

    task automatic test_branch_fill();
        int t;
        do_reset();
        dec_ready = 1'b1; force_miss_addr = 32'h1004; force_armed = 1;
        t = 0;
        while (fetch_stall !== 1'b1 && t < 10) begin cycle(); t++; end
        n_total++; if (fetch_stall !== 1'b1) $display("FAIL bf_timeout: got stall=%b expected 1", fetch_stall); else n_pass++;
        branch_hit = 1'b1; PCbranch = 32'h3000; ic_fill_done = 1'b1;
        cycle();
        n_total++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h3000) $display("FAIL bf_target: got %b/%h expected 1/00003000", ic_req, ic_addr);
        else n_pass++;
        repeat (6) cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) cycle();
        n_total++; if (dec_valid !== 1'b1) $display("FAIL ar_setup: got %b expected 1", dec_valid); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++; if (ic_req !== 1'b0) $display("FAIL ar_ic_req: got %b expected 0", ic_req); else n_pass++;
        n_total++; if (dec_valid !== 1'b0) $display("FAIL ar_dec_valid: got %b expected 0", dec_valid); else n_pass++;
        n_total++; if (instruction !== 32'h0 || PCnext !== 32'h0) $display("FAIL ar_head: got %h/%h expected 0/0", instruction, PCnext); else n_pass++;
        do_reset();
        n_total++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h1000) $display("FAIL ar_restart: got %b/%h expected 1/00001000", ic_req, ic_addr);
        else n_pass++;
        dec_ready = 1'b1;
        repeat (4) cycle();
    endtask

    task automatic test_random();
        do_reset();
        miss_pct = 15;
        repeat (800) begin
            dec_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                branch_hit = 1'b1;
                PCbranch = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            end
            if (fetch_stall === 1'b1 && $urandom_range(0, 2) == 0) ic_fill_done = 1'b1;
            else if ($urandom_range(0, 40) == 0) ic_fill_done = 1'b1;
            cycle();
        end
        n_total++; if (n_pop == 0) $display("FAIL rnd_progress: got 0 pops expected > 0"); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_miss();
        test_branch();
        test_branch_fill();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule
